// File: rtl/data_ram_bytelane.sv
// data_ram_bytelane: single-port, byte-addressed 32-bit data memory for the
// load/store path. Byte/half/word stores merge into the selected lanes, loads
// are sign- or zero-extended, misaligned/illegal accesses raise err, read data
// is registered, and an optional sweep zeroes the whole array after reset.
module data_ram_bytelane #(
  parameter int DEPTH          = 1024,
  parameter int AW             = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          err
);

  localparam int CW = AW - 2;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  logic [31:0]   mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [CW-1:0] widx;
  logic [1:0]    lane;
  logic          acc;
  logic          fault;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rword;

  // Pick the addressed byte or halfword out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] ln, input logic zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = zext ? {24'd0, b} : 32'(b);
      2'b01:   r = zext ? {16'd0, h} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  assign widx  = addr[AW-1:2];
  assign lane  = addr[1:0];
  assign acc   = req & ready_q;
  assign fault = (size == 2'b11) ||
                 ((size == 2'b01) && addr[0]) ||
                 ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign rword = mem[widx];

  // Lane enables and replicated store data for byte/half/word stores.
  always_comb begin
    be    = 4'hF;
    wword = wdata;
    case (size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wword = wdata;
      end
    endcase
  end

  // Next-state: clear sweep sequencing, acceptance and load response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DEPTH - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
    ready_d = (state_d == ST_IDLE);
    if (acc) begin
      err_d = fault;
      if (!we) begin
        rvalid_d = 1'b1;
        rdata_d  = fault ? 32'd0 : load_extend(rword, size, lane, uns);
      end
    end
  end

  // FSM state, sweep counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array writes: zeroing during the sweep, lane-merged stores when idle.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= 32'd0;
    end else if (acc && we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_ram_bytelane.sv
// tb_data_ram_bytelane: randomized and directed bench for data_ram_bytelane
// (DEPTH=16) against a byte-array reference model of the memory.
module tb_data_ram_bytelane;

  localparam int DEPTH = 16;
  localparam int AW    = 6;
  localparam int NB    = DEPTH * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          uns = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          ready;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          err;

  data_ram_bytelane #(.DEPTH(DEPTH), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0]  mref [NB];
  logic        exp_ready;
  logic [31:0] exp_rdata;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Assert reset, check the reset outputs, release just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    exp_ready = 1'b0;
    exp_rdata = 32'd0;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Run n sweep cycles with random requests; ready must rise exactly after cycle 16.
  task automatic sweep(input int n);
    for (int k = 1; k <= n; k++) begin
      req = 1'($urandom); we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
      addr = AW'($urandom); wdata = $urandom;
      @(posedge clk); #1;
      check("sweep_ready", ready, (k == DEPTH));
      check("sweep_rvalid", rvalid, 1'b0);
      check("sweep_err", err, 1'b0);
    end
    req = 1'b0;
    if (n == DEPTH) begin
      exp_ready = 1'b1;
      for (int i = 0; i < NB; i++) mref[i] = 8'd0;
    end
  endtask

  // One cycle of stimulus; the model predicts the response seen after the edge.
  task automatic xact(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [AW-1:0] a, input logic [31:0] wd);
    int          nb;
    logic        flt, acc, exp_rvalid, exp_err;
    logic [31:0] v;
    req = r; we = w; size = sz; uns = u; addr = a; wdata = wd;
    nb  = 1 << sz;
    flt = (sz == 2'b11) || ((int'(a) % nb) != 0);
    acc = r && exp_ready;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    if (acc) begin
      exp_err = flt;
      if (!w) begin
        exp_rvalid = 1'b1;
        if (flt) exp_rdata = 32'd0;
        else begin
          v = 32'd0;
          for (int i = 0; i < nb; i++) v = v | (32'(mref[int'(a) + i]) << (8 * i));
          if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
          exp_rdata = v;
        end
      end else if (!flt) begin
        for (int i = 0; i < nb; i++) mref[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end
    end
    @(posedge clk); #1;
    check("ready", ready, exp_ready);
    check("rvalid", rvalid, exp_rvalid);
    check("err", err, exp_err);
    check("rdata", rdata, exp_rdata);
  endtask

  logic [31:0] t2_s [4] = '{32'hFFFFFFE1, 32'hFFFFFFF0, 32'h00000021, 32'hFFFFFF84};
  logic [31:0] t2_u [4] = '{32'h000000E1, 32'h000000F0, 32'h00000021, 32'h00000084};

  initial begin
    for (int i = 0; i < NB; i++) mref[i] = 8'($urandom);

    // Reset, full sweep with requests ignored, every word reads 0.
    do_reset();
    sweep(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b1, 1'b0, 2'b10, 1'b0, AW'(i * 4), 32'd0);
      check("t1_zero", rdata, 32'd0);
    end

    // Word store then signed and unsigned byte loads.
    xact(1'b1, 1'b1, 2'b10, 1'b0, 6'h08, 32'h8421F0E1);
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b0, 2'b00, 1'b0, AW'(8 + i), 32'd0);
      check("t2_sext", rdata, t2_s[i]);
    end
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b0, 2'b00, 1'b1, AW'(8 + i), 32'd0);
      check("t2_zext", rdata, t2_u[i]);
    end

    // Lane merge, load right after store.
    xact(1'b1, 1'b1, 2'b00, 1'b0, 6'h09, 32'hFFFFFF5A);
    xact(1'b1, 1'b1, 2'b01, 1'b0, 6'h0A, 32'hFFFFBEEF);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'd0);
    check("t3_merge", rdata, 32'hBEEF5AE1);

    // Faults.
    xact(1'b1, 1'b1, 2'b10, 1'b0, 6'h04, 32'h0BADF00D);
    xact(1'b1, 1'b1, 2'b01, 1'b0, 6'h05, 32'h00001234);
    check("t4_st_err", err, 1'b1);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h04, 32'd0);
    check("t4_unchanged", rdata, 32'h0BADF00D);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h06, 32'd0);
    check("t4_ld_err", err, 1'b1);
    check("t4_ld_rdata", rdata, 32'd0);
    xact(1'b1, 1'b0, 2'b11, 1'b0, 6'h00, 32'd0);
    check("t4_sz3_err", err, 1'b1);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'd0);

    // Back-to-back loads.
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h00, 32'd0);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h04, 32'd0);
    xact(1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'd0);
    check("t6_last", rdata, 32'hBEEF5AE1);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'd0);

    // Random traffic, alignment biased so most accesses are legal.
    for (int n = 0; n < 400; n++) begin
      logic [1:0]    sz;
      logic [AW-1:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = AW'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~AW'((1 << sz) - 1);
      xact(1'($urandom_range(0, 4) != 0), 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    // Reset mid-sweep restarts it; memory reads back all zero.
    do_reset();
    sweep(5);
    do_reset();
    sweep(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b1, 1'b0, 2'b10, 1'b0, AW'(i * 4), 32'd0);
      check("t5_zero", rdata, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
